// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: RAW hazard detection and RUN/STALL/FREEZE sequencing for the ID stage
module hazard_stall_controller #(
  parameter int REG_AW        = 4,
  parameter int NUM_SRC       = 3,
  parameter int CNT_W         = 8,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic                      exe_wb_en,
  input  logic                      exe_mem_r_en,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      mem_wb_en,
  input  logic                      mem_ready,
  input  logic                      fwd_en,
  input  logic                      processor_mode,
  output logic                      hazard_detected,
  output logic                      freeze,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          hazard_events,
  output logic                      stall_timeout
);
  localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FREEZE = 2'd2;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(STALL_TIMEOUT);
  logic [NUM_SRC-1:0] ex_hit, mem_hit;
  logic raw;
  logic [1:0] state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign ex_hit[i]  = src_valid[i] & exe_wb_en & (src_addr[i*REG_AW +: REG_AW] == exe_dest);
    assign mem_hit[i] = src_valid[i] & mem_wb_en & (src_addr[i*REG_AW +: REG_AW] == mem_dest);
  end
  // with forwarding only a load in EXE cannot be bypassed in time
  assign raw = ~processor_mode & (fwd_en ? (|ex_hit) & exe_mem_r_en : |(ex_hit | mem_hit));
  assign hazard_detected = raw & rst;
  assign freeze = ~mem_ready & rst;
  always_comb begin
    state_nxt = freeze ? S_FREEZE : raw ? S_STALL : S_RUN;
    count_nxt = state_nxt == S_RUN    ? '0 :
                state_nxt == S_FREEZE ? stall_count :
                state == S_STALL      ? (&stall_count ? stall_count : stall_count + CNT_W'(1)) :
                state == S_RUN        ? CNT_W'(1) : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state         <= S_RUN;
      stall_count   <= '0;
      hazard_events <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_count <= count_nxt;
      if (state_nxt == S_STALL && state != S_STALL) hazard_events <= hazard_events + CNT_W'(1);
      if (count_nxt == TMO) stall_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and randomized checks against an episode-level reference model
module tb_hazard_stall_controller;
  localparam int REG_AW = 4, NUM_SRC = 3, CNT_W = 8, STALL_TIMEOUT = 16;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst;
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_SRC-1:0] src_valid;
  logic [REG_AW-1:0] exe_dest, mem_dest;
  logic exe_wb_en, exe_mem_r_en, mem_wb_en, mem_ready, fwd_en, processor_mode;
  logic hazard_detected, freeze, stall_timeout;
  logic [CNT_W-1:0] stall_count, hazard_events;
  typedef enum int {M_RUN, M_STALL, M_FREEZE} mstate_t;
  mstate_t ms;
  int mc, me, n_tests, n_fail;
  bit mt;
  string phase;
  hazard_stall_controller #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .STALL_TIMEOUT(STALL_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_ready(mem_ready), .fwd_en(fwd_en), .processor_mode(processor_mode),
    .hazard_detected(hazard_detected), .freeze(freeze), .stall_count(stall_count),
    .hazard_events(hazard_events), .stall_timeout(stall_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s/%s got %0d expected %0d", phase, tag, got, exp);
    end
  endtask
  // a source is a hazard if it reads a register still being produced by an unbypassable writer
  function automatic bit m_raw();
    bit r;
    int a;
    bit e, m;
    r = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = int'((src_addr >> (i * REG_AW)) & 12'hF);
      e = exe_wb_en && a == int'(exe_dest);
      m = mem_wb_en && a == int'(mem_dest);
      if (src_valid[i] && (fwd_en ? (e && exe_mem_r_en) : (e || m))) r = 1;
    end
    return processor_mode ? 1'b0 : r;
  endfunction
  task automatic model_edge();
    bit r;
    r = m_raw();
    if (!rst) begin
      ms = M_RUN; mc = 0; me = 0; mt = 0;
      return;
    end
    if (!mem_ready) ms = M_FREEZE;
    else if (r) begin
      if (ms == M_STALL) mc = (mc < CMAX) ? mc + 1 : CMAX;
      else begin
        mc = (ms == M_RUN) ? 1 : 0;
        me = (me + 1) % (CMAX + 1);
      end
      ms = M_STALL;
    end else begin
      ms = M_RUN; mc = 0;
    end
    if (mc == STALL_TIMEOUT) mt = 1;
  endtask
  task automatic cycle();
    #1;
    check("hazard", hazard_detected, int'(rst && m_raw()));
    check("freeze", freeze, int'(rst && !mem_ready));
    model_edge();
    @(posedge clk);
    #1;
    check("count", stall_count, mc);
    check("events", hazard_events, me);
    check("timeout", stall_timeout, mt);
  endtask
  task automatic idle();
    rst = 1; src_addr = '0; src_valid = '0; exe_dest = 0; mem_dest = 0;
    exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0; mem_ready = 1; fwd_en = 0; processor_mode = 0;
  endtask
  task automatic src0_hit3();
    idle(); src_addr = 12'h003; src_valid = 3'b001; exe_dest = 3; exe_wb_en = 1;
  endtask
  initial begin
    n_tests = 0; n_fail = 0;
    ms = M_RUN; mc = 0; me = 0; mt = 0;
    phase = "reset";
    src0_hit3(); rst = 0; mem_ready = 0;
    repeat (2) cycle();
    check("cnt0", stall_count, 0);
    phase = "t1";
    src0_hit3();
    cycle();
    check("cnt1", stall_count, 1);
    check("ev1", hazard_events, 1);
    idle(); cycle();
    phase = "t2";
    src0_hit3(); fwd_en = 1; cycle();
    exe_mem_r_en = 1; cycle();
    exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 1; mem_dest = 3; cycle();
    check("fwd_mem", hazard_detected, 0);
    phase = "t3";
    idle(); src_addr = 12'h500; src_valid = 3'b011; exe_dest = 5; exe_wb_en = 1; cycle();
    src_valid = 3'b111; cycle();
    processor_mode = 1; mem_wb_en = 1; mem_dest = 5; cycle();
    idle(); cycle();
    phase = "t4";
    src0_hit3();
    repeat (15) cycle();
    check("to15", stall_timeout, 0);
    cycle();
    check("to16", stall_timeout, 1);
    idle(); cycle();
    check("to_sticky", stall_timeout, 1);
    check("cnt_run", stall_count, 0);
    phase = "t5";
    src0_hit3(); repeat (4) cycle();
    mem_ready = 0; repeat (3) cycle();
    check("frz_hold", stall_count, 4);
    mem_ready = 1; cycle();
    check("frz_restart", stall_count, 0);
    cycle();
    phase = "t6";
    idle(); cycle(); src0_hit3(); repeat (7) cycle();
    check("cnt7", stall_count, 7);
    rst = 0; cycle();
    rst = 1; cycle();
    phase = "sat";
    src0_hit3(); repeat (260) cycle();
    check("sat", stall_count, CMAX);
    phase = "wrap";
    for (int k = 0; k < 258; k++) begin
      src0_hit3(); cycle(); idle(); cycle();
    end
    phase = "rand";
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      for (int i = 0; i < NUM_SRC; i++) src_addr[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      src_valid = NUM_SRC'($urandom);
      exe_dest = REG_AW'($urandom_range(0, 3)); mem_dest = REG_AW'($urandom_range(0, 3));
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom); mem_wb_en = 1'($urandom);
      mem_ready = $urandom_range(0, 99) < 80; fwd_en = 1'($urandom);
      processor_mode = $urandom_range(0, 99) < 10;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
